// File: rtl/fb_wr_arbiter.sv
// Round-robin write arbiter for the frame-buffer RAM write port.
// Counts accepted writes per frame and stalls once the frame is full.
module fb_wr_arbiter #(
  parameter int NR = 4,
  parameter int DW = 8,
  parameter int MD = 1024,
  parameter int AW = $clog2(MD),
  parameter int CW = $clog2(MD+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic [NR-1:0]    req_vld,
  input  logic [NR*AW-1:0] req_adr,
  input  logic [NR*DW-1:0] req_dat,
  output logic [NR-1:0]    req_rdy,
  output logic            ram_we,
  output logic [AW-1:0]    ram_adr,
  output logic [DW-1:0]    ram_dat,
  input  logic            frame_clr,
  output logic [CW-1:0]    wr_cnt,
  output logic            frame_done
);

  localparam int PW = $clog2(NR);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] nptr;
  logic          found;
  logic          gate;
  logic          xfer;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat;

  // Search starts at ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin : grant_p
    int j;
    logic [PW-1:0] idx;
    gate  = clk_en & ~frame_done & ~frame_clr;
    found = 1'b0;
    gidx  = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < NR; k++) begin
      j = int'(ptr) + k;
      if (j >= NR) j = j - NR;
      idx = PW'(j);
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    xfer    = gate & found;
    req_rdy = '0;
    if (xfer) req_rdy[gidx] = 1'b1;
    sel_adr = req_adr[gidx*AW +: AW];
    sel_dat = req_dat[gidx*DW +: DW];
    nptr    = (gidx == PW'(NR-1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we     <= 1'b0;
      ram_adr    <= '0;
      ram_dat    <= '0;
      ptr        <= '0;
      wr_cnt     <= '0;
      frame_done <= 1'b0;
    end else if (clk_en) begin
      ram_we <= xfer;
      if (xfer) begin
        ram_adr <= sel_adr;
        ram_dat <= sel_dat;
        ptr     <= nptr;
      end
      if (frame_clr) begin
        wr_cnt     <= '0;
        frame_done <= 1'b0;
      end else if (xfer) begin
        wr_cnt     <= wr_cnt + 1'b1;
        frame_done <= (wr_cnt + 1'b1 == CW'(MD));
      end
    end
  end

endmodule
